learn_song_sequencer: RTL and testbench
=======================================

// Module: learn_song_sequencer
// PURPOSE
//  Upstream note source for the learn-mode falling-block display. Walks a song ROM entry by entry.
//  Presents note[7:0]/shift[1:0]/output_ready so the display shifts in one block row per step.
//  Holds each note for its encoded duration, then inserts a rest gap so consecutive blocks stay visually separate.
//  step is pulsed by top level whenever the display scroller advances one row.
// PARAMETERS
//  ADDR_W      6    song ROM address width; song length up to 2**ADDR_W entries
//  GAP_SLOTS   1    rest slots (output_ready=0) after every note; 0 = no gap
//  DUR_W       5    duration field width, in step slots
// PORTS
//  vga_clk       in   1       system clock (same domain as display)
//  rst           in   1       synchronous, active-high reset
//  start         in   1       1-cycle pulse: begin song from address 0
//  stop          in   1       1-cycle pulse: abort song, return to idle
//  step          in   1       1-cycle pulse: display consumed one row
//  rom_addr      out  ADDR_W  song ROM address
//  rom_data      in   16      [7:0] note one-hot/chord, [9:8] shift, [14:10] duration, [15] end marker
//  note          out  8       current note bits to display
//  shift         out  2       octave: 01 low, 00 middle, 10 high
//  output_ready  out  1       1 = note valid for current row; 0 = rest row
//  busy          out  1       song in progress
//  done          out  1       1-cycle pulse on song completion (not on stop)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rom_addr 0, counters 0, pending-step flag 0.
//  ROM: synchronous, 1-cycle read latency; rom_data valid the cycle after rom_addr changes.
//  FSM states IDLE, FETCH, WAIT, HOLD, GAP.
//   IDLE: busy=0, output_ready=0. start -> FETCH with rom_addr=0.
//   FETCH: address presented; -> WAIT next cycle.
//   WAIT: latch rom_data. end bit=1 -> IDLE, pulse done, note/shift/output_ready cleared.
//     Else note/shift loaded, output_ready=1, dur_cnt = duration (0 treated as 1) -> HOLD.
//   HOLD: each step decrements dur_cnt.
//     On step with dur_cnt==1: GAP_SLOTS>0 -> GAP (output_ready=0, note kept, gap_cnt=GAP_SLOTS).
//     GAP_SLOTS==0 -> advance.
//   GAP: each step decrements gap_cnt; on last -> advance.
//   advance: rom_addr==2**ADDR_W-1 -> IDLE + done (no wrap); else rom_addr+1 -> FETCH.
//  output_ready valid exactly while in HOLD; in FETCH/WAIT previous output_ready held at 0.
//  Steps arriving in FETCH/WAIT latched in pending flag, consumed on entry to HOLD.
//  At most one step pending; second is dropped.
//  Step period >= 3 cycles guaranteed by top level.
//  stop in any state: IDLE next cycle, outputs cleared, no done pulse; stop wins over same-cycle start/step.
//  start while busy: ignored. start and step same cycle in IDLE: start taken, step dropped.
//  rst mid-song: returns to reset values next edge, same as stop but rom_addr also 0.
//  busy=1 in FETCH/WAIT/HOLD/GAP. done never coincides with busy rising.
// STRUCTURE
//  Shared package: ROM field offsets (NOTE_LSB=0, SHIFT_LSB=8, DUR_LSB=10, END_BIT=15).
//  Shared package also holds shift encodings SHIFT_LOW/MID/HIGH and the FSM state enum.
//  One natural sub-module: song_rom (sync-read ROM, $readmemh init), instantiated at top level, not inside.
//  Sequencer itself: single FSM plus dur_cnt/gap_cnt counters.
// TESTING
//  ROM[0]=note 0x01 shift 00 dur 2; start, 4 steps -> output_ready 1 for rows 1-2, 0 row 3; note 0x02 row 4.
//  ROM[0] end bit set; start -> done pulse 2 cycles later, busy 0, output_ready stays 0.
//  Duration 0 entry, shift 10 -> treated as 1 row; shift=10 presented; GAP follows.
//  Stop during HOLD at row 3 of a 5-row note -> next cycle all outputs 0, busy 0, no done.
//  Step pulsed in WAIT cycle -> pending consumed; note advances as if step came in HOLD.
//  Full 64-entry ROM, no end marker, GAP_SLOTS=0 -> rom_addr stops at 63, done once, no wrap.
//  Reset asserted mid-GAP -> all outputs and rom_addr 0 next edge.
//  start while busy -> ignored, song position unchanged.

Source files
------------

// File: rtl/learn_song_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : learn_song_sequencer_pkg
// Purpose  : Song ROM field layout, octave encodings and sequencer state type.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package learn_song_sequencer_pkg;

  localparam int ROM_W     = 16;
  localparam int NOTE_W    = 8;
  localparam int SHIFT_W   = 2;
  localparam int NOTE_LSB  = 0;
  localparam int SHIFT_LSB = 8;
  localparam int DUR_LSB   = 10;
  localparam int END_BIT   = 15;

  localparam logic [SHIFT_W-1:0] SHIFT_LOW  = 2'b01;
  localparam logic [SHIFT_W-1:0] SHIFT_MID  = 2'b00;
  localparam logic [SHIFT_W-1:0] SHIFT_HIGH = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/learn_song_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : learn_song_sequencer_if
// Purpose  : Control, song ROM and display-row signals of the note sequencer.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface learn_song_sequencer_if #(
  parameter int ADDR_W = 6
) ();
  import learn_song_sequencer_pkg::*;

  logic                 start;
  logic                 stop;
  logic                 step;
  logic [ADDR_W-1:0]    rom_addr;
  logic [ROM_W-1:0]     rom_data;
  logic [NOTE_W-1:0]    note;
  logic [SHIFT_W-1:0]   shift;
  logic                 output_ready;
  logic                 busy;
  logic                 done;

  // master is the sequencer, slave is the display/top-level side
  modport master (
    input  start, stop, step, rom_data,
    output rom_addr, note, shift, output_ready, busy, done
  );

  modport slave (
    output start, stop, step, rom_data,
    input  rom_addr, note, shift, output_ready, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/learn_song_sequencer_song_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : learn_song_sequencer_song_rom
// Purpose  : Synchronous-read song ROM, one cycle latency, parameter initialised.
// Revision : 1.1  contents supplied through INIT parameter
// ----------------------------------------------------------------------------
module learn_song_sequencer_song_rom
    import learn_song_sequencer_pkg::*;
#(
    parameter int                                ADDR_W = 6,
    parameter logic [ROM_W*(2**ADDR_W)-1:0]      INIT   = '0
) (
    input  wire logic              vga_clk,
    input  wire logic [ADDR_W-1:0] addr,
    output      logic [ROM_W-1:0]  data
);

    logic [ROM_W-1:0] r_data;

    always_ff @(posedge vga_clk) begin
        r_data <= INIT[int'(addr)*ROM_W +: ROM_W];
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/learn_song_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : learn_song_sequencer
// Purpose  : Walks the song ROM and feeds one block row per display step,
//            holding each note for its duration followed by rest rows.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module learn_song_sequencer
  import learn_song_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int GAP_SLOTS = 1,
  parameter int DUR_W     = 5
) (
  input wire logic               vga_clk,
  input wire logic               rst,
  learn_song_sequencer_if.master bus
);

  localparam int GAP_W = (GAP_SLOTS < 2) ? 1 : $clog2(GAP_SLOTS + 1);

  seq_state_t         r_state,    w_state;
  logic [ADDR_W-1:0]  r_rom_addr, w_rom_addr;
  logic [NOTE_W-1:0]  r_note,     w_note;
  logic [SHIFT_W-1:0] r_shift,    w_shift;
  logic               r_ready,    w_ready;
  logic               r_done,     w_done;
  logic               r_pending,  w_pending;
  logic [DUR_W-1:0]   r_dur_cnt,  w_dur_cnt;
  logic [GAP_W-1:0]   r_gap_cnt,  w_gap_cnt;

  logic               w_step_now;
  logic               w_advance;
  logic [DUR_W-1:0]   w_dur_field;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rom_addr <= '0;
      r_note     <= '0;
      r_shift    <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_pending  <= 1'b0;
      r_dur_cnt  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state;
      r_rom_addr <= w_rom_addr;
      r_note     <= w_note;
      r_shift    <= w_shift;
      r_ready    <= w_ready;
      r_done     <= w_done;
      r_pending  <= w_pending;
      r_dur_cnt  <= w_dur_cnt;
      r_gap_cnt  <= w_gap_cnt;
    end
  end

  assign w_dur_field = bus.rom_data[DUR_LSB +: DUR_W];
  // a step latched while the note was being fetched counts as the first HOLD step
  assign w_step_now  = bus.step | r_pending;

  always_comb begin
    w_state    = r_state;
    w_rom_addr = r_rom_addr;
    w_note     = r_note;
    w_shift    = r_shift;
    w_ready    = r_ready;
    w_done     = 1'b0;
    w_pending  = r_pending;
    w_dur_cnt  = r_dur_cnt;
    w_gap_cnt  = r_gap_cnt;
    w_advance  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pending = 1'b0;
        if (bus.start) begin
          w_state    = ST_FETCH;
          w_rom_addr = '0;
        end
      end

      ST_FETCH: begin
        if (bus.step) w_pending = 1'b1;
        w_state = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.step) w_pending = 1'b1;
        if (bus.rom_data[END_BIT]) begin
          w_state   = ST_IDLE;
          w_done    = 1'b1;
          w_note    = '0;
          w_shift   = '0;
          w_ready   = 1'b0;
          w_pending = 1'b0;
        end else begin
          w_state   = ST_HOLD;
          w_note    = bus.rom_data[NOTE_LSB +: NOTE_W];
          w_shift   = bus.rom_data[SHIFT_LSB +: SHIFT_W];
          w_ready   = 1'b1;
          w_dur_cnt = (w_dur_field == '0) ? DUR_W'(1) : w_dur_field;
        end
      end

      ST_HOLD: begin
        w_pending = 1'b0;
        if (w_step_now) begin
          if (r_dur_cnt <= DUR_W'(1)) begin
            w_dur_cnt = '0;
            if (GAP_SLOTS > 0) begin
              w_state   = ST_GAP;
              w_ready   = 1'b0;
              w_gap_cnt = GAP_W'(GAP_SLOTS);
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            w_dur_cnt = r_dur_cnt - DUR_W'(1);
          end
        end
      end

      ST_GAP: begin
        w_pending = 1'b0;
        if (w_step_now) begin
          if (r_gap_cnt <= GAP_W'(1)) begin
            w_gap_cnt = '0;
            w_advance = 1'b1;
          end else begin
            w_gap_cnt = r_gap_cnt - GAP_W'(1);
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // the song never wraps: running off the last address ends it
    if (w_advance) begin
      w_ready = 1'b0;
      if (&r_rom_addr) begin
        w_state = ST_IDLE;
        w_done  = 1'b1;
        w_note  = '0;
        w_shift = '0;
      end else begin
        w_state    = ST_FETCH;
        w_rom_addr = r_rom_addr + ADDR_W'(1);
      end
    end

    if (bus.stop) begin
      w_state   = ST_IDLE;
      w_note    = '0;
      w_shift   = '0;
      w_ready   = 1'b0;
      w_done    = 1'b0;
      w_pending = 1'b0;
      w_dur_cnt = '0;
      w_gap_cnt = '0;
    end
  end

  assign bus.rom_addr     = r_rom_addr;
  assign bus.note         = r_note;
  assign bus.shift        = r_shift;
  assign bus.output_ready = r_ready;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_learn_song_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_learn_song_sequencer
// Purpose  : Two sequencers (GAP_SLOTS 1 and 0) driven by the same stimulus,
//            compared row by row against a song-expansion reference model.
// ----------------------------------------------------------------------------
module tb_learn_song_sequencer;
  import learn_song_sequencer_pkg::*;

  logic vga_clk = 1'b0;
  logic rst;
  always #5 vga_clk = ~vga_clk;

  learn_song_sequencer_if #(.ADDR_W(6)) bus_g1 ();
  learn_song_sequencer_if #(.ADDR_W(6)) bus_g0 ();

  learn_song_sequencer #(.ADDR_W(6), .GAP_SLOTS(1), .DUR_W(5)) dut_g1 (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus_g1)
  );

  learn_song_sequencer #(.ADDR_W(6), .GAP_SLOTS(0), .DUR_W(5)) dut_g0 (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus_g0)
  );

  logic [15:0] rom_mem [64];

  always @(posedge vga_clk) begin
    bus_g1.rom_data <= rom_mem[bus_g1.rom_addr];
    bus_g0.rom_data <= rom_mem[bus_g0.rom_addr];
  end

  typedef struct packed {
    logic [7:0] note;
    logic [1:0] shift;
    logic       ready;
    logic [5:0] addr;
  } row_t;

  row_t rows_g0[$];
  row_t rows_g1[$];
  int   last_addr;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_g0  = 0;
  int   done_g1  = 0;

  always @(negedge vga_clk) begin
    if (bus_g0.done) done_g0++;
    if (bus_g1.done) done_g1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic set_ctl(input logic st, input logic sp, input logic se);
    bus_g1.start = st; bus_g1.stop = sp; bus_g1.step = se;
    bus_g0.start = st; bus_g0.stop = sp; bus_g0.step = se;
  endtask

  // Expand the ROM into the rows the display should see, one per step.
  task automatic build_model();
    logic [15:0] e;
    int d;
    rows_g0.delete();
    rows_g1.delete();
    last_addr = 63;
    for (int a = 0; a < 64; a++) begin
      e = rom_mem[a];
      if (e[15]) begin
        last_addr = a;
        break;
      end
      d = int'(e[14:10]);
      if (d == 0) d = 1;
      for (int r = 0; r < d; r++) begin
        rows_g0.push_back({e[7:0], e[9:8], 1'b1, 6'(a)});
        rows_g1.push_back({e[7:0], e[9:8], 1'b1, 6'(a)});
      end
      rows_g1.push_back({e[7:0], e[9:8], 1'b0, 6'(a)});
    end
  endtask

  task automatic check_dut(input string pfx, input row_t rq[$], input int k,
                           input logic [7:0] note, input logic [1:0] shift,
                           input logic ready, input logic busy, input logic [5:0] addr);
    if (k < rq.size()) begin
      check($sformatf("%s_note@%0d", pfx, k),  note,  rq[k].note);
      check($sformatf("%s_shift@%0d", pfx, k), shift, rq[k].shift);
      check($sformatf("%s_ready@%0d", pfx, k), ready, rq[k].ready);
      check($sformatf("%s_busy@%0d", pfx, k),  busy,  1);
      check($sformatf("%s_addr@%0d", pfx, k),  addr,  rq[k].addr);
    end else begin
      check($sformatf("%s_idle_note@%0d", pfx, k),  note,  0);
      check($sformatf("%s_idle_shift@%0d", pfx, k), shift, 0);
      check($sformatf("%s_idle_ready@%0d", pfx, k), ready, 0);
      check($sformatf("%s_idle_busy@%0d", pfx, k),  busy,  0);
      check($sformatf("%s_idle_addr@%0d", pfx, k),  addr,  last_addr);
    end
  endtask

  task automatic check_rows(input int k);
    check_dut("g1", rows_g1, k, bus_g1.note, bus_g1.shift, bus_g1.output_ready, bus_g1.busy, bus_g1.rom_addr);
    check_dut("g0", rows_g0, k, bus_g0.note, bus_g0.shift, bus_g0.output_ready, bus_g0.busy, bus_g0.rom_addr);
  endtask

  task automatic check_cleared(input string tag, input bit addr_zero);
    check({tag, "_g1_ready"}, bus_g1.output_ready, 0);
    check({tag, "_g1_note"},  bus_g1.note, 0);
    check({tag, "_g1_shift"}, bus_g1.shift, 0);
    check({tag, "_g1_busy"},  bus_g1.busy, 0);
    check({tag, "_g1_done"},  bus_g1.done, 0);
    check({tag, "_g0_ready"}, bus_g0.output_ready, 0);
    check({tag, "_g0_busy"},  bus_g0.busy, 0);
    check({tag, "_g0_done"},  bus_g0.done, 0);
    if (addr_zero) begin
      check({tag, "_g1_addr"}, bus_g1.rom_addr, 0);
      check({tag, "_g0_addr"}, bus_g0.rom_addr, 0);
    end
  endtask

  // pend: 0 = first step in HOLD, 1 = in FETCH, 2 = in WAIT.
  // abort_kind: 0 none, 1 stop, 2 reset, taken after step abort_at.
  task automatic run_song(input int pend, input int abort_kind, input int abort_at, input int restart_at);
    int d0, d1, nsteps;
    build_model();
    d0 = done_g0;
    d1 = done_g1;
    nsteps = rows_g1.size() + 1;
    set_ctl(1, 0, 0);
    tick(1);
    set_ctl(0, 0, 0);
    if (pend == 0) begin
      tick(4);
      check_rows(0);
    end else if (pend == 2) begin
      tick(1);
    end
    for (int k = 1; k <= nsteps; k++) begin
      set_ctl(0, 0, 1);
      tick(1);
      set_ctl(0, 0, 0);
      tick(5);
      check_rows(k);
      if (k == restart_at) begin
        set_ctl(1, 0, 0);
        tick(1);
        set_ctl(0, 0, 0);
        tick(3);
        check_rows(k);
      end
      if (k == abort_at && abort_kind == 1) begin
        set_ctl(0, 1, 0);
        tick(1);
        set_ctl(0, 0, 0);
        check_cleared("stop", 0);
        tick(8);
        check("stop_no_done_g1", done_g1 - d1, 0);
        check("stop_no_done_g0", done_g0 - d0, 0);
        return;
      end
      if (k == abort_at && abort_kind == 2) begin
        rst = 1'b1;
        tick(1);
        check_cleared("rst", 1);
        rst = 1'b0;
        tick(2);
        return;
      end
    end
    check("done_once_g1", done_g1 - d1, 1);
    check("done_once_g0", done_g0 - d0, 1);
  endtask

  task automatic fill_end();
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'h8000;
  endtask

  task automatic fill_random(input int len, input int max_dur);
    logic [1:0] sh;
    logic [7:0] nt;
    logic [4:0] du;
    fill_end();
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 2))
        0:       sh = SHIFT_LOW;
        1:       sh = SHIFT_MID;
        default: sh = SHIFT_HIGH;
      endcase
      nt = 8'($urandom_range(1, 255));
      du = 5'($urandom_range(0, max_dur));
      rom_mem[i] = {1'b0, du, sh, nt};
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_ctl(0, 0, 0);
    fill_end();
    tick(3);
    check_cleared("reset", 1);
    rst = 1'b0;
    tick(2);

    // note 0x01 held two rows, rest row, then note 0x02
    fill_end();
    rom_mem[0] = 16'h0801;
    rom_mem[1] = 16'h0402;
    run_song(0, 0, -1, -1);

    // end marker at address 0: done two cycles after start
    fill_end();
    set_ctl(1, 0, 0);
    tick(1);
    set_ctl(0, 0, 0);
    check("end0_busy", bus_g1.busy, 1);
    tick(1);
    check("end0_done_early", bus_g1.done, 0);
    tick(1);
    check("end0_done_g1", bus_g1.done, 1);
    check("end0_done_g0", bus_g0.done, 1);
    check("end0_busy_off", bus_g1.busy, 0);
    check("end0_ready", bus_g1.output_ready, 0);
    tick(1);
    check("end0_done_pulse", bus_g1.done, 0);

    // zero duration, high octave
    fill_end();
    rom_mem[0] = {1'b0, 5'd0, SHIFT_HIGH, 8'h81};
    rom_mem[1] = {1'b0, 5'd1, SHIFT_LOW, 8'h10};
    run_song(0, 0, -1, -1);

    // stop on the third row of a five-row note
    fill_end();
    rom_mem[0] = {1'b0, 5'd5, SHIFT_MID, 8'h04};
    run_song(0, 1, 2, -1);

    // steps arriving in FETCH and in WAIT
    fill_random(4, 3);
    run_song(1, 0, -1, -1);
    fill_random(4, 3);
    run_song(2, 0, -1, -1);

    // reset while the GAP_SLOTS=1 sequencer is in its rest row
    fill_end();
    rom_mem[0] = {1'b0, 5'd1, SHIFT_MID, 8'h20};
    rom_mem[1] = {1'b0, 5'd2, SHIFT_LOW, 8'h40};
    run_song(0, 2, 1, -1);

    // start while busy is ignored
    fill_end();
    rom_mem[0] = {1'b0, 5'd2, SHIFT_MID, 8'h03};
    rom_mem[1] = {1'b0, 5'd3, SHIFT_HIGH, 8'h0C};
    run_song(0, 0, -1, 1);

    for (int s = 0; s < 6; s++) begin
      fill_random($urandom_range(1, 8), 4);
      run_song($urandom_range(0, 2), 0, -1, -1);
    end

    // full ROM without end marker: stops at the last address
    fill_random(64, 2);
    run_song(0, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
